// File: rtl/fft_stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the radix-2 DIT FFT stage sequencer.
//   seq_fsm       : sequencer state encoding (IDLE / ISSUE / DRAIN)
//   log2_res_t    : result of log2_pow2() -- valid flag plus log2(N)
//   log2_pow2()   : priority-encodes N and qualifies it as a supported
//                   power of two (2 <= N <= 2^max_log2)
// -----------------------------------------------------------------------------
package fft_pkg;

   localparam int MAX_LOG2_DEF        = 11;
   localparam int MAX_OUTSTANDING_DEF = 4;

   typedef enum logic [1:0] {
      seq_IDLE,
      seq_ISSUE,
      seq_DRAIN
   } seq_fsm;

   typedef struct packed {
      logic       valid;
      logic [3:0] log2n;
   } log2_res_t;

   // Highest set bit gives L; N is accepted only when exactly one bit is set
   // and that bit lies in 1..max_log2 (N = 1 has L = 0 and is rejected).
   function automatic log2_res_t log2_pow2(input logic [15:0] n, input int max_log2);
      log2_res_t res;
      logic      one_hot;
      res.log2n = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (n[i]) res.log2n = 4'(i);
      end
      one_hot   = (n != 16'd0) && ((n & (n - 16'd1)) == 16'd0);
      res.valid = one_hot && (res.log2n != 4'd0) && (int'(res.log2n) <= max_log2);
      return res;
   endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_bf_addr_gen
// Combinational butterfly address / twiddle generator for an in-place
// radix-2 DIT FFT whose input already sits in bit-reversed order.
// Ports:
//   stage_i    : stage s (0..L-1)
//   bf_idx_i   : butterfly index j within the stage (0..N/2-1)
//   log2n_i    : L = log2(N)
//   addr_a_o   : upper-wing RAM index  = grp*2*half + pos
//   addr_b_o   : lower-wing RAM index  = addr_a + half
//   twiddle_o  : twiddle index k       = pos << (L-1-s)
// -----------------------------------------------------------------------------
module fft_bf_addr_gen #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic [3:0]            stage_i,
   input  logic [ADDR_WIDTH-1:0] bf_idx_i,
   input  logic [3:0]            log2n_i,
   output logic [ADDR_WIDTH-1:0] addr_a_o,
   output logic [ADDR_WIDTH-1:0] addr_b_o,
   output logic [ADDR_WIDTH-2:0] twiddle_o
);

   logic [ADDR_WIDTH-1:0] half;
   logic [ADDR_WIDTH-1:0] pos;
   logic [ADDR_WIDTH-1:0] grp;
   logic [3:0]            tw_shift;

   assign half = ADDR_WIDTH'(1) << stage_i;
   assign pos  = bf_idx_i & (half - ADDR_WIDTH'(1));
   assign grp  = bf_idx_i >> stage_i;

   // grp * 2 * half is a shift by s+1
   assign addr_a_o = (grp << (stage_i + 4'd1)) + pos;
   assign addr_b_o = addr_a_o + half;

   // pos < half <= N/2, so it always fits in the narrower twiddle width
   assign tw_shift  = log2n_i - 4'd1 - stage_i;
   assign twiddle_o = pos[ADDR_WIDTH-2:0] << tw_shift;

endmodule

// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
// Walks the in-place radix-2 DIT FFT over the sample RAM: for every stage it
// issues each butterfly descriptor (address pair + twiddle index) over a
// valid/ready handshake, limits the butterflies in flight, and lets a stage
// drain completely before the next one starts. Raises o_CALC_END at the end.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : start pulse, ignored while busy
//   i_SAMPLES_NUMBER    : N, sampled on an accepted start
//   o_bf_valid/i_bf_ready : descriptor handshake
//   o_addr_a, o_addr_b  : butterfly RAM indices
//   o_twiddle_idx       : twiddle ROM index k for W_N^k
//   o_stage             : current stage 0..L-1
//   i_bf_done           : one pulse per completed butterfly write-back
//   o_busy              : transform in progress
//   o_CALC_END          : transform complete, held until the next start
//   o_err               : last start carried an unsupported N
// -----------------------------------------------------------------------------
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int ADDR_WIDTH      = 12,
   parameter int MAX_LOG2        = MAX_LOG2_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
   output logic                  o_bf_valid,
   input  logic                  i_bf_ready,
   output logic [ADDR_WIDTH-1:0] o_addr_a,
   output logic [ADDR_WIDTH-1:0] o_addr_b,
   output logic [ADDR_WIDTH-2:0] o_twiddle_idx,
   output logic [3:0]            o_stage,
   input  logic                  i_bf_done,
   output logic                  o_busy,
   output logic                  o_CALC_END,
   output logic                  o_err
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   seq_fsm                state_q;
   logic [3:0]            stage_q;
   logic [3:0]            log2n_q;
   logic [ADDR_WIDTH-1:0] bf_idx_q;
   logic [ADDR_WIDTH-1:0] last_idx_q;
   logic [OUT_W-1:0]      outst_q;
   logic [OUT_W-1:0]      outst_d;
   logic                  valid_q;
   logic                  busy_q;
   logic                  calc_end_q;
   logic                  err_q;
   logic [ADDR_WIDTH-1:0] addr_a_q;
   logic [ADDR_WIDTH-1:0] addr_b_q;
   logic [ADDR_WIDTH-2:0] twiddle_q;

   log2_res_t             start_res;
   logic                  handshake;
   logic                  done_ok;
   logic                  outst_full;

   logic [3:0]            gen_stage;
   logic [ADDR_WIDTH-1:0] gen_idx;
   logic [3:0]            gen_log2n;
   logic [ADDR_WIDTH-1:0] gen_addr_a;
   logic [ADDR_WIDTH-1:0] gen_addr_b;
   logic [ADDR_WIDTH-2:0] gen_twiddle;

   assign start_res = log2_pow2(16'(i_SAMPLES_NUMBER), MAX_LOG2);

   // A done with nothing in flight is a protocol error and is dropped, so the
   // counter saturates at zero instead of wrapping.
   assign handshake  = valid_q & i_bf_ready;
   assign done_ok    = i_bf_done & (outst_q != '0);
   assign outst_d    = outst_q + OUT_W'(handshake) - OUT_W'(done_ok);
   assign outst_full = (outst_d == OUT_W'(MAX_OUTSTANDING));

   // The generator always computes the descriptor that will be loaded into
   // the output registers at the next load event: the first one of a fresh
   // transform, the first one of the next stage, or j+1 within the stage.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case can infer a latch.
      gen_stage = stage_q;
      gen_idx   = bf_idx_q + ADDR_WIDTH'(1);
      gen_log2n = log2n_q;
      case (state_q)
         seq_IDLE: begin
            gen_stage = '0;
            gen_idx   = '0;
            gen_log2n = start_res.log2n;
         end
         seq_DRAIN: begin
            gen_stage = stage_q + 4'd1;
            gen_idx   = '0;
         end
         default: ;
      endcase
   end

   fft_bf_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .stage_i   (gen_stage),
      .bf_idx_i  (gen_idx),
      .log2n_i   (gen_log2n),
      .addr_a_o  (gen_addr_a),
      .addr_b_o  (gen_addr_b),
      .twiddle_o (gen_twiddle)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= seq_IDLE;
         stage_q    <= '0;
         log2n_q    <= '0;
         bf_idx_q   <= '0;
         last_idx_q <= '0;
         outst_q    <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         calc_end_q <= 1'b0;
         err_q      <= 1'b0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         twiddle_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register here sees the pre-edge value of every other register.
         outst_q <= outst_d;
         case (state_q)
            seq_IDLE: begin
               if (i_start) begin
                  if (start_res.valid) begin
                     state_q    <= seq_ISSUE;
                     stage_q    <= '0;
                     bf_idx_q   <= '0;
                     log2n_q    <= start_res.log2n;
                     last_idx_q <= (ADDR_WIDTH'(1) << (start_res.log2n - 4'd1)) - ADDR_WIDTH'(1);
                     valid_q    <= 1'b1;
                     busy_q     <= 1'b1;
                     calc_end_q <= 1'b0;
                     err_q      <= 1'b0;
                     addr_a_q   <= gen_addr_a;
                     addr_b_q   <= gen_addr_b;
                     twiddle_q  <= gen_twiddle;
                  end else begin
                     err_q      <= 1'b1;
                     calc_end_q <= 1'b0;
                  end
               end
            end

            seq_ISSUE: begin
               if (handshake && (bf_idx_q == last_idx_q)) begin
                  state_q <= seq_DRAIN;
                  valid_q <= 1'b0;
               end else begin
                  // Outstanding only grows on a handshake, so a presented
                  // descriptor is never withdrawn while stalled.
                  valid_q <= ~outst_full;
                  if (handshake) begin
                     bf_idx_q  <= bf_idx_q + ADDR_WIDTH'(1);
                     addr_a_q  <= gen_addr_a;
                     addr_b_q  <= gen_addr_b;
                     twiddle_q <= gen_twiddle;
                  end
               end
            end

            seq_DRAIN: begin
               if (outst_q == '0) begin
                  if (stage_q != (log2n_q - 4'd1)) begin
                     state_q   <= seq_ISSUE;
                     stage_q   <= stage_q + 4'd1;
                     bf_idx_q  <= '0;
                     valid_q   <= 1'b1;
                     addr_a_q  <= gen_addr_a;
                     addr_b_q  <= gen_addr_b;
                     twiddle_q <= gen_twiddle;
                  end else begin
                     state_q    <= seq_IDLE;
                     busy_q     <= 1'b0;
                     calc_end_q <= 1'b1;
                  end
               end
            end

            default: state_q <= seq_IDLE;
         endcase
      end
   end

   assign o_bf_valid    = valid_q;
   assign o_addr_a      = addr_a_q;
   assign o_addr_b      = addr_b_q;
   assign o_twiddle_idx = twiddle_q;
   assign o_stage       = stage_q;
   assign o_busy        = busy_q;
   assign o_CALC_END    = calc_end_q;
   assign o_err         = err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Directed bench for fft_stage_sequencer. Expected descriptors are built from
// the textbook DIT loop nest (stage / group / position, k = p * N/(2*half))
// and queued when a transform is started; each presented descriptor is
// compared against the queue head, popped on handshake. Write-back dones are
// returned a fixed number of cycles after each handshake.
// -----------------------------------------------------------------------------
module tb_fft_stage_sequencer;

   localparam int AW = 12;

   typedef struct packed {
      logic [3:0]    stage;
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      logic [AW-2:0] k;
   } desc_t;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_start;
   logic [AW-1:0] i_SAMPLES_NUMBER;
   logic          o_bf_valid;
   logic          i_bf_ready;
   logic [AW-1:0] o_addr_a;
   logic [AW-1:0] o_addr_b;
   logic [AW-2:0] o_twiddle_idx;
   logic [3:0]    o_stage;
   logic          i_bf_done;
   logic          o_busy;
   logic          o_CALC_END;
   logic          o_err;

   int    checks = 0;
   int    errors = 0;
   desc_t exp_q[$];
   int    due_q[$];

   fft_stage_sequencer #(
      .ADDR_WIDTH      (AW),
      .MAX_LOG2        (11),
      .MAX_OUTSTANDING (4)
   ) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_start          (i_start),
      .i_SAMPLES_NUMBER (i_SAMPLES_NUMBER),
      .o_bf_valid       (o_bf_valid),
      .i_bf_ready       (i_bf_ready),
      .o_addr_a         (o_addr_a),
      .o_addr_b         (o_addr_b),
      .o_twiddle_idx    (o_twiddle_idx),
      .o_stage          (o_stage),
      .i_bf_done        (i_bf_done),
      .o_busy           (o_busy),
      .o_CALC_END       (o_CALC_END),
      .o_err            (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_valid"},   32'(o_bf_valid),    32'd0);
      check({pfx, "_addr_a"},  32'(o_addr_a),      32'd0);
      check({pfx, "_addr_b"},  32'(o_addr_b),      32'd0);
      check({pfx, "_twiddle"}, 32'(o_twiddle_idx), 32'd0);
      check({pfx, "_stage"},   32'(o_stage),       32'd0);
      check({pfx, "_busy"},    32'(o_busy),        32'd0);
      check({pfx, "_calc_end"},32'(o_CALC_END),    32'd0);
      check({pfx, "_err"},     32'(o_err),         32'd0);
   endtask

   task automatic push_model(input int n);
      desc_t d;
      for (int s = 0; (1 << s) < n; s++) begin
         int half;
         half = 1 << s;
         for (int g = 0; g < n; g += 2 * half) begin
            for (int p = 0; p < half; p++) begin
               d.stage = 4'(s);
               d.a     = AW'(g + p);
               d.b     = AW'(g + p + half);
               d.k     = (AW-1)'(p * (n / (2 * half)));
               exp_q.push_back(d);
            end
         end
      end
   endtask

   // ready_mode 0: always ready, 1: random ready.
   // hold_until > 0: dones withheld until that cycle.
   // inject_at / reset_at: cycle of a stray start / mid-run reset (-1 = none).
   task automatic run_fft(input int n, input int ready_mode, input int hold_until,
                          input int inject_at, input int reset_at, input int budget);
      int    hs_cnt;
      int    ends;
      int    bench_out;
      int    last_stage;
      int    total;
      bit    was_reset;
      logic  prev_end;
      desc_t d;
      hs_cnt = 0; ends = 0; bench_out = 0; last_stage = 0; was_reset = 1'b0;
      exp_q.delete();
      due_q.delete();
      push_model(n);
      total = exp_q.size();

      i_SAMPLES_NUMBER = AW'(n);
      i_start          = 1'b1;
      i_bf_done        = 1'b0;
      i_bf_ready       = 1'b1;
      step();
      i_start = 1'b0;
      check("start_valid",     32'(o_bf_valid), 32'd1);
      check("start_busy",      32'(o_busy),     32'd1);
      check("start_err_clr",   32'(o_err),      32'd0);
      check("start_end_clr",   32'(o_CALC_END), 32'd0);
      prev_end = o_CALC_END;

      for (int c = 0; c < budget; c++) begin
         if (c == reset_at) begin
            check("rst_mid_stage", 32'(o_stage), 32'd1);
            i_rst = 1'b1; i_bf_ready = 1'b0; i_bf_done = 1'b0; i_start = 1'b0;
            step();
            i_rst = 1'b0;
            check_all_zero("rst_mid");
            was_reset = 1'b1;
            break;
         end

         if (o_CALC_END && !prev_end) begin
            ends++;
            check("end_after_drain", 32'(bench_out == 0 && exp_q.size() == 0), 32'd1);
            check("end_busy", 32'(o_busy), 32'd0);
         end
         prev_end = o_CALC_END;
         if (ends > 0) break;

         if (hold_until > 0 && c == hold_until - 1) begin
            check("held_issue_cnt", 32'(hs_cnt), 32'd4);
            check("held_valid",     32'(o_bf_valid), 32'd0);
         end

         if (o_bf_valid) begin
            check("valid_under_limit", 32'(bench_out < 4), 32'd1);
            if (exp_q.size() == 0) begin
               check("extra_desc", 32'(o_bf_valid), 32'd0);
            end else begin
               check("desc_stage", 32'(o_stage),       32'(exp_q[0].stage));
               check("desc_a",     32'(o_addr_a),      32'(exp_q[0].a));
               check("desc_b",     32'(o_addr_b),      32'(exp_q[0].b));
               check("desc_k",     32'(o_twiddle_idx), 32'(exp_q[0].k));
            end
         end

         i_bf_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (c == inject_at) begin
            i_start          = 1'b1;
            i_SAMPLES_NUMBER = AW'(16);
         end else begin
            i_start = 1'b0;
         end

         if (o_bf_valid && i_bf_ready && exp_q.size() > 0) begin
            d = exp_q.pop_front();
            if (int'(d.stage) != last_stage) check("stage_after_drain", 32'(bench_out), 32'd0);
            last_stage = int'(d.stage);
            hs_cnt++;
            bench_out++;
            due_q.push_back(c + 2);
         end

         i_bf_done = 1'b0;
         if (c >= hold_until && due_q.size() > 0 && due_q[0] <= c) begin
            i_bf_done = 1'b1;
            void'(due_q.pop_front());
            bench_out--;
         end
         step();
      end

      i_bf_done  = 1'b0;
      i_start    = 1'b0;
      i_bf_ready = 1'b0;
      if (!was_reset) begin
         check("calc_end_seen", 32'(ends),   32'd1);
         check("hs_total",      32'(hs_cnt), 32'(total));
         step();
         check("end_held",  32'(o_CALC_END), 32'd1);
         check("end_valid", 32'(o_bf_valid), 32'd0);
         check("end_busy2", 32'(o_busy),     32'd0);
      end
      exp_q.delete();
      due_q.delete();
   endtask

   task automatic bad_start(input int n, input string tag);
      i_SAMPLES_NUMBER = AW'(n);
      i_start          = 1'b1;
      step();
      i_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check({tag, "_err"},   32'(o_err),      32'd1);
         check({tag, "_valid"}, 32'(o_bf_valid), 32'd0);
         check({tag, "_busy"},  32'(o_busy),     32'd0);
         check({tag, "_end"},   32'(o_CALC_END), 32'd0);
         step();
      end
   endtask

   initial begin
      i_rst            = 1'b1;
      i_start          = 1'b0;
      i_SAMPLES_NUMBER = '0;
      i_bf_ready       = 1'b0;
      i_bf_done        = 1'b0;
      @(negedge i_clk);
      step();
      step();
      i_rst = 1'b0;
      check_all_zero("reset");
      step();

      // N=8, always ready, done two cycles after each issue
      run_fft(8, 0, -1, -1, -1, 200);

      // N=8, dones withheld: exactly four issues, then stall
      run_fft(8, 0, 12, -1, -1, 200);

      // N=16, random ready: stability while stalled, 32 handshakes
      run_fft(16, 1, -1, -1, -1, 600);

      // Invalid N values, then a good start clears o_err
      bad_start(12, "n12");
      bad_start(0, "n0");
      run_fft(4, 0, -1, -1, -1, 100);

      // Reset in the middle of stage 1 of N=1024, then a fresh N=2
      run_fft(1024, 0, -1, -1, 600, 1200);
      run_fft(2, 0, -1, -1, -1, 50);

      // Stray start with N=16 during ISSUE of N=8 is ignored
      run_fft(8, 0, -1, 2, -1, 200);

      // Spurious dones while idle must not disturb the counter
      i_bf_done = 1'b1;
      step();
      step();
      step();
      i_bf_done = 1'b0;
      check("idle_done_valid", 32'(o_bf_valid), 32'd0);
      run_fft(2, 0, -1, -1, -1, 50);

      // Largest supported transform, N=2048
      run_fft(2048, 0, -1, -1, -1, 12000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
